// File: rtl/la_capture_writer.sv
// Run-length-encoding capture writer for the logic-analyzer RAM: circular pre-trigger queue, linear post-trigger fill, bookkeeping word at the last address.
// Optional LA_TRIGGER_EDGE_EN: trigger only on entering the match condition (default is level trigger).
module la_capture_writer #(
   parameter int DATA_W             = 24,
   parameter int CNT_W              = 8,
   parameter int ADDR_W             = 6,
   parameter int MAX_CNT            = 253,
   parameter int BT_QUEUE_TAIL_ADDR = 23,
   parameter int MEM_LAST_ADDR      = 63,
   parameter logic [DATA_W-1:0] TRIG_MASK  = 24'h00FFFF,
   parameter logic [DATA_W-1:0] TRIG_VALUE = 24'h000503
) (
   input  logic                    clk_of_verifla,
   input  logic                    rst,
   input  logic                    arm,
   input  logic [DATA_W-1:0]       data_in,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W+CNT_W-1:0] mem_din,
   output logic                    la_trigger_matched,
   output logic                    busy,
   output logic                    capture_done
);

   localparam logic [ADDR_W-1:0] L_TAIL       = ADDR_W'(BT_QUEUE_TAIL_ADDR);
   localparam logic [ADDR_W-1:0] L_POST_FIRST = ADDR_W'(BT_QUEUE_TAIL_ADDR + 1);
   localparam logic [ADDR_W-1:0] L_POST_LAST  = ADDR_W'(MEM_LAST_ADDR - 1);
   localparam logic [ADDR_W-1:0] L_LAST       = ADDR_W'(MEM_LAST_ADDR);
   localparam logic [CNT_W-1:0]  L_MAX        = CNT_W'(MAX_CNT);
   localparam logic [CNT_W-1:0]  L_ONE        = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_PRE,
      S_POST,
      S_BOOK,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_runVal;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_tail;
   logic                r_first;

   logic                w_match;
   logic                w_trig;
   logic                w_extend;
   logic [CNT_W-1:0]    w_cntInc;
   logic [ADDR_W-1:0]   w_preNext;

   assign w_match = (data_in & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK);

`ifdef LA_TRIGGER_EDGE_EN
   logic r_prevMatch;

   // Tracks the match state of the previous sample in every state, so a stream already matching before PRE cannot trigger.
   always_ff @(posedge clk_of_verifla or posedge rst) begin
      if (rst) r_prevMatch <= 1'b0;
      else     r_prevMatch <= w_match;
   end

   assign w_trig = w_match && !r_prevMatch;
`else
   assign w_trig = w_match;
`endif

   // r_first forces the first sample after CLEAR onto a fresh line at address 0.
   assign w_extend  = !r_first && (data_in == r_runVal) && (r_cnt < L_MAX);
   assign w_cntInc  = r_cnt + L_ONE;
   assign w_preNext = (r_first || mem_addr == L_TAIL) ? '0 : mem_addr + 1'b1;

   always_ff @(posedge clk_of_verifla or posedge rst) begin
      if (rst) begin
         r_state            <= S_IDLE;
         r_runVal           <= '0;
         r_cnt              <= '0;
         r_tail             <= '0;
         r_first            <= 1'b0;
         mem_we             <= 1'b0;
         mem_addr           <= '0;
         mem_din            <= '0;
         la_trigger_matched <= 1'b0;
         busy               <= 1'b0;
         capture_done       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  r_state            <= S_CLEAR;
                  mem_we             <= 1'b1;
                  mem_addr           <= '0;
                  mem_din            <= '0;
                  busy               <= 1'b1;
                  capture_done       <= 1'b0;
                  la_trigger_matched <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (mem_addr == L_LAST) begin
                  r_state <= S_PRE;
                  mem_we  <= 1'b0;
                  r_first <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  mem_addr <= mem_addr + 1'b1;
               end
            end
            S_PRE: begin
               r_first <= 1'b0;
               mem_we  <= 1'b1;
               if (w_trig) begin
                  r_tail             <= r_first ? L_TAIL : mem_addr;
                  mem_addr           <= L_POST_FIRST;
                  r_cnt              <= L_ONE;
                  r_runVal           <= data_in;
                  mem_din            <= {data_in, L_ONE};
                  la_trigger_matched <= 1'b1;
                  r_state            <= S_POST;
               end else if (w_extend) begin
                  r_cnt   <= w_cntInc;
                  mem_din <= {data_in, w_cntInc};
               end else begin
                  mem_addr <= w_preNext;
                  r_cnt    <= L_ONE;
                  r_runVal <= data_in;
                  mem_din  <= {data_in, L_ONE};
               end
            end
            S_POST: begin
               if (w_extend) begin
                  r_cnt   <= w_cntInc;
                  mem_din <= {data_in, w_cntInc};
               end else if (mem_addr == L_POST_LAST) begin
                  // Region full: this sample is dropped and the bookkeeping word goes out instead.
                  r_state  <= S_BOOK;
                  mem_addr <= L_LAST;
                  mem_din  <= (DATA_W + CNT_W)'(r_tail);
               end else begin
                  mem_addr <= mem_addr + 1'b1;
                  r_cnt    <= L_ONE;
                  r_runVal <= data_in;
                  mem_din  <= {data_in, L_ONE};
               end
            end
            S_BOOK: begin
               r_state      <= S_DONE;
               mem_we       <= 1'b0;
               busy         <= 1'b0;
               capture_done <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               mem_we  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_la_capture_writer.sv
// Self-checking bench for la_capture_writer: write scoreboard fed by a sample-level model, plus final RAM-image tables.
module tb_la_capture_writer;

   localparam logic [23:0] TRIG_MASK  = 24'h00FFFF;
   localparam logic [23:0] TRIG_VALUE = 24'h000503;

   logic        clk_of_verifla = 1'b0;
   logic        rst            = 1'b1;
   logic        arm            = 1'b0;
   logic [23:0] data_in        = '0;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_din;
   logic        la_trigger_matched;
   logic        busy;
   logic        capture_done;

   la_capture_writer dut (
      .clk_of_verifla     (clk_of_verifla),
      .rst                (rst),
      .arm                (arm),
      .data_in            (data_in),
      .mem_we             (mem_we),
      .mem_addr           (mem_addr),
      .mem_din            (mem_din),
      .la_trigger_matched (la_trigger_matched),
      .busy               (busy),
      .capture_done       (capture_done)
   );

   always #5 clk_of_verifla = ~clk_of_verifla;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] din;
   } wrT;

   typedef struct {
      int          addr;
      logic [31:0] word;
   } vecT;

   wrT          expQ[$];
   vecT         tbl[$];
   logic [31:0] ram [64];
   int          checks = 0;
   int          errors = 0;

   // Sample-level reference of the capture format
   int          mPhase = 0;
   logic [5:0]  mAddr  = '0;
   logic [5:0]  mTail  = '0;
   logic [7:0]  mCnt   = '0;
   logic [23:0] mRun   = '0;
   bit          mFirst = 1'b0;
   bit          mMatched = 1'b0;
   bit          mPrevMatch = 1'b0;

   function automatic bit isMatch(input logic [23:0] d);
      return (d & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [23:0] d, input bit a);
      wrT e;
      data_in = d;
      arm     = a;
      @(posedge clk_of_verifla);
      #1;
      arm        = 1'b0;
      mPrevMatch = isMatch(d);
      if (mem_we) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write actual addr=%0d data=%h required no write", mem_addr, mem_din);
         end else begin
            e = expQ.pop_front();
            checkOutput("write_addr", 32'(mem_addr), 32'(e.addr));
            checkOutput("write_data", mem_din, e.din);
         end
         ram[mem_addr] = mem_din;
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL missing_write actual no write required addr=%0d", expQ[0].addr);
         expQ.delete();
      end
   endtask

   task automatic armCapture(input logic [23:0] d, input int armAgainAt);
      for (int i = 0; i < 64; i++) begin
         expQ.push_back('{addr: 6'(i), din: 32'h0});
         applyStimulus(d, (i == 0) || (i == armAgainAt));
         checkOutput("busy_clear", 32'(busy), 32'd1);
         if (i == 0) begin
            checkOutput("matched_cleared", 32'(la_trigger_matched), 32'd0);
            checkOutput("done_cleared", 32'(capture_done), 32'd0);
         end
      end
      applyStimulus(d, 1'b0);
      checkOutput("busy_gap", 32'(busy), 32'd1);
      mPhase   = 1;
      mFirst   = 1'b1;
      mMatched = 1'b0;
   endtask

   task automatic captureSample(input logic [23:0] d);
      bit trig;
      trig = (mPhase == 1) && isMatch(d);
`ifdef LA_TRIGGER_EDGE_EN
      trig = trig && !mPrevMatch;
`endif
      if (mPhase == 1) begin
         if (trig) begin
            mTail    = mFirst ? 6'd23 : mAddr;
            mAddr    = 6'd24;
            mCnt     = 8'd1;
            mRun     = d;
            mMatched = 1'b1;
            mPhase   = 2;
         end else if (!mFirst && d == mRun && mCnt < 8'd253) begin
            mCnt = mCnt + 8'd1;
         end else begin
            mAddr = (mFirst || mAddr == 6'd23) ? 6'd0 : 6'(mAddr + 6'd1);
            mCnt  = 8'd1;
            mRun  = d;
         end
         mFirst = 1'b0;
         expQ.push_back('{addr: mAddr, din: {mRun, mCnt}});
      end else if (mPhase == 2) begin
         if (d == mRun && mCnt < 8'd253) begin
            mCnt = mCnt + 8'd1;
            expQ.push_back('{addr: mAddr, din: {mRun, mCnt}});
         end else if (mAddr == 6'd62) begin
            expQ.push_back('{addr: 6'd63, din: 32'(mTail)});
            mPhase = 3;
         end else begin
            mAddr = 6'(mAddr + 6'd1);
            mCnt  = 8'd1;
            mRun  = d;
            expQ.push_back('{addr: mAddr, din: {mRun, mCnt}});
         end
      end
      applyStimulus(d, 1'b0);
      checkOutput("trigger_matched", 32'(la_trigger_matched), 32'(mMatched));
   endtask

   task automatic postToggleAndFinish();
      for (int i = 0; i < 100 && mPhase == 2; i++)
         captureSample((i % 2) ? 24'h555555 : 24'hAAAAAA);
      checkOutput("post_region_filled", 32'(mPhase), 32'd3);
      applyStimulus(24'h0, 1'b0);
      checkOutput("capture_done", 32'(capture_done), 32'd1);
      checkOutput("busy_done", 32'(busy), 32'd0);
      checkOutput("matched_sticky", 32'(la_trigger_matched), 32'd1);
      applyStimulus(24'h0, 1'b0);
      checkOutput("done_holds", 32'(capture_done), 32'd1);
   endtask

   task automatic checkTable();
      foreach (tbl[k])
         checkOutput($sformatf("line%0d", tbl[k].addr), ram[tbl[k].addr], tbl[k].word);
      tbl.delete();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting");
      repeat (3) @(posedge clk_of_verifla);
      #1;
      checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset_mem_din", mem_din, 32'd0);
      checkOutput("reset_matched", 32'(la_trigger_matched), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(capture_done), 32'd0);
      @(negedge clk_of_verifla);
      rst = 1'b0;
      applyStimulus(24'h0, 1'b0);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      // Long constant run split over three lines, then trigger
      tbl.push_back('{0,  32'h100000FD});
      tbl.push_back('{1,  32'h100000FD});
      tbl.push_back('{2,  32'h1000005E});
      tbl.push_back('{3,  32'h00000000});
      tbl.push_back('{24, 32'h00050301});
      tbl.push_back('{63, 32'h00000002});
      armCapture(24'h0, -1);
      for (int i = 0; i < 600; i++) captureSample(24'h100000);
      captureSample(24'h000503);
      postToggleAndFinish();
      checkTable();

      // Queue wrap, re-armed from DONE, with an ignored arm pulse during CLEAR
      for (int i = 0; i < 24; i++) tbl.push_back('{i, 32'h123456FD});
      tbl.push_back('{24, 32'h00050301});
      tbl.push_back('{63, 32'h00000005});
      armCapture(24'h123456, 10);
      for (int i = 0; i < 30 * 253; i++) captureSample(24'h123456);
      captureSample(24'h000503);
      postToggleAndFinish();
      checkTable();

      // Trigger on the very first PRE sample
      for (int i = 0; i < 24; i++) tbl.push_back('{i, 32'h00000000});
      tbl.push_back('{24, 32'h00050301});
      tbl.push_back('{25, 32'hAAAAAA01});
      tbl.push_back('{63, 32'h00000017});
      armCapture(24'h0, -1);
      captureSample(24'h000503);
      postToggleAndFinish();
      checkTable();

`ifdef LA_TRIGGER_EDGE_EN
      // Already matching from arm: no trigger until the stream leaves and re-enters
      tbl.push_back('{0,  32'h00050314});
      tbl.push_back('{1,  32'h00000005});
      tbl.push_back('{24, 32'h00050301});
      tbl.push_back('{63, 32'h00000001});
      armCapture(24'h000503, -1);
      for (int i = 0; i < 20; i++) captureSample(24'h000503);
      checkOutput("edge_no_trigger", 32'(la_trigger_matched), 32'd0);
      for (int i = 0; i < 5; i++) captureSample(24'h000000);
      captureSample(24'h000503);
      checkOutput("edge_reentry_trigger", 32'(la_trigger_matched), 32'd1);
      postToggleAndFinish();
      checkTable();
`endif

      // Asynchronous reset in the middle of POST
      armCapture(24'h0, -1);
      captureSample(24'h000503);
      for (int i = 0; i < 3; i++) captureSample((i % 2) ? 24'h555555 : 24'hAAAAAA);
      @(negedge clk_of_verifla);
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("midrst_matched", 32'(la_trigger_matched), 32'd0);
      checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("midrst_done", 32'(capture_done), 32'd0);
      expQ.delete();
      mPhase     = 0;
      mPrevMatch = 1'b0;
      @(negedge clk_of_verifla);
      rst = 1'b0;
      applyStimulus(24'h000503, 1'b0);
      checkOutput("after_rst_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
